taxi_arb_rr: RTL
================

# taxi_arb_rr

Registered round-robin arbiter for N requesters. Each cycle it picks one winner from the request vector and holds the grant until the configured release condition. It uses two internal priority encoders: one over the round-robin-masked requests and one over the unmasked requests. It sits directly upstream of shared-resource muxes, such as MAC TX source selection and statistics bus sharing, which consume the grant one-hot and index.

## Interface
- `PORTS`, default 4: number of requesters (≥1).
- `ARB_ROUND_ROBIN`, default 1: 1 = round-robin; 0 = fixed priority.
- `ARB_BLOCK`, default 1: 1 = hold grant until release; 0 = re-arbitrate every cycle.
- `ARB_BLOCK_ACK`, default 1: with `ARB_BLOCK`=1, 1 = release on `ack[grant_index]`; 0 = release when `req[grant_index]` drops.
- `LSB_HIGH_PRIO`, default 0: 1 = bit 0 has the highest base priority; 0 = bit `PORTS-1` has the highest base priority.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req` in `PORTS`: request per port, level.
- `ack` in `PORTS`: release strobe per port; only `ack[grant_index]` is honoured.
- `grant` out `PORTS`: one-hot grant, registered.
- `grant_valid` out 1: any grant active, registered.
- `grant_index` out `$clog2(PORTS)` (min 1): index of the granted port, registered.

## Operation
- **State registers.**
  - `grant`, `grant_valid`, `grant_index`.
  - `rr_mask[PORTS]`: round-robin mask, marks ports eligible ahead of the wrap.
- **Reset values.** While `rst_n`=0, all outputs and `rr_mask` are 0 asynchronously.
- **Release (`rel`), evaluated each cycle.**
  - `!grant_valid`, or
  - `ARB_BLOCK`=0, or
  - `ARB_BLOCK_ACK`=1 and `ack[grant_index]`, or
  - `ARB_BLOCK_ACK`=0 and `!req[grant_index]`.
- **Hold.** If `!rel`: all registers hold. `req` and `ack` on other ports have no effect.
- **Winner selection.** If `rel`:
  - `masked = req & rr_mask`.
  - Winner = encoder(`masked`) if `masked`≠0 and `ARB_ROUND_ROBIN`=1; otherwise encoder(`req`).
  - Encoder priority follows `LSB_HIGH_PRIO`.
- **Register update on release.**
  - If the winner is valid: `grant <= 1<<win`, `grant_index <= win`, `grant_valid <= 1`.
  - If no winner: `grant <= 0`, `grant_valid <= 0`, `grant_index` holds its last value.
- **Round-robin mask update** (only when a new grant is issued, `ARB_ROUND_ROBIN`=1):
  - `LSB_HIGH_PRIO`=1: `rr_mask <= ~((2<<win)-1)`, i.e. ports above `win`.
  - `LSB_HIGH_PRIO`=0: `rr_mask <= (1<<win)-1`, i.e. ports below `win`.
  - `rr_mask` = 0 after the last port is served gives natural wrap to the unmasked encoder.
- **Re-grant to the same port.** The releasing port is excluded only through `rr_mask`. If it is the sole requester, it is re-granted on the same edge.
- **Fixed priority.** With `ARB_ROUND_ROBIN`=0, `rr_mask` stays 0.
- **Widths.**
  - `PORTS`=1 is legal: `grant_index` is always 0 and `rr_mask` is always 0.
  - Inputs above `PORTS` do not exist; there is no padding visible at the ports.

## Timing
- **Latency.** One cycle from a `req` rising edge (with the arbiter free) to `grant`.
- **Hand-over.** One cycle from the release condition to the next grant, with no idle bubble: the release cycle's edge loads the next winner.
- **Ack mode.** `ack` is sampled on the same edge as `req`. An `ack` in the cycle `grant` first rises is honoured, giving a one-cycle grant.
- **Simultaneous events.** When `ack` and a new `req` on another port arrive in the same cycle, the new `req` participates in that cycle's arbitration.
- **Reset mid-grant.** Outputs clear immediately on assertion of `rst_n`. The first post-reset grant uses `rr_mask`=0.
- **Combinational paths.** There is no combinational path from inputs to outputs.

## Test plan
Default configuration unless stated: `PORTS`=4, `LSB_HIGH_PRIO`=1, `ARB_ROUND_ROBIN`=1, `ARB_BLOCK`=1, `ARB_BLOCK_ACK`=1.
- **Reset values.** Reset with `req`=4'b1111 → `grant`=0, `grant_valid`=0, `grant_index`=0 while `rst_n`=0. After release, the first grant is 4'b0001 on the next edge.
- **Basic handshake.**
  - `req`=4'b1010 → `grant`=4'b0010, `grant_index`=1 one cycle later; held for 5 cycles with `ack`=0.
  - `ack`=4'b0010 for one cycle → next edge `grant`=4'b1000, `grant_index`=3.
  - `ack`=4'b0100 (non-granted port) during the hold → no change.
- **Fairness.** `req`=4'b1111 constant, `ack`=`grant` every cycle → grants cycle 0001, 0010, 0100, 1000, 0001, with no repeats or gaps.
- **Sole requester re-grant.** `req`=4'b0100 only, `ack` pulsed → `grant` stays 4'b0100 with `grant_valid` continuously 1. Dropping `req` together with `ack` → `grant_valid`=0 next edge, `grant_index` holds 2.
- **Asynchronous reset mid-grant.** Assert `rst_n` between edges while `grant`=4'b1000 → outputs 0 without waiting for a `clk` edge. After release with `req`=4'b1001 → `grant`=4'b0001.
- **Configuration variants.**
  - `ARB_BLOCK_ACK`=0: grant is held while `req[i]` stays high; dropping `req[i]` hands over in 1 cycle.
  - `ARB_ROUND_ROBIN`=0 with `req`=4'b0011 and `ack` every cycle → port 0 is always granted.
  - `LSB_HIGH_PRIO`=0 with `req`=4'b0011 → first grant is port 1.

Source files
------------

// File: rtl/taxi_arb_rr.sv
// Registered round-robin / fixed-priority arbiter with blocking grant.
// Two priority encoders (masked and unmasked requests) pick the next winner on release.
module taxi_arb_rr #(
    parameter int PORTS           = 4,
    parameter int ARB_ROUND_ROBIN = 1,
    parameter int ARB_BLOCK       = 1,
    parameter int ARB_BLOCK_ACK   = 1,
    parameter int LSB_HIGH_PRIO   = 0,
    localparam int IDX_W          = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] req,
    input  logic [PORTS-1:0] ack,
    output logic [PORTS-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_index
);

    logic [PORTS-1:0] r_grant;
    logic             r_grant_valid;
    logic [IDX_W-1:0] r_grant_index;
    logic [PORTS-1:0] r_rr_mask;

    logic             w_rel;
    logic [PORTS-1:0] w_masked;
    logic [IDX_W:0]   w_enc_m;
    logic [IDX_W:0]   w_enc_u;
    logic [IDX_W:0]   w_win;
    logic [PORTS-1:0] w_grant_nxt;
    logic [PORTS-1:0] w_mask_nxt;

    // Returns {valid, index} of the highest-priority set bit of v.
    function automatic logic [IDX_W:0] f_prio_enc(input logic [PORTS-1:0] v);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (LSB_HIGH_PRIO != 0) begin
                if (v[PORTS-1-i]) begin
                    res = {1'b1, IDX_W'(PORTS-1-i)};
                end
            end else begin
                if (v[i]) begin
                    res = {1'b1, IDX_W'(i)};
                end
            end
        end
        return res;
    endfunction

    // Release condition, winner selection and next grant / mask values.
    always_comb begin
        w_rel       = 1'b0;
        w_grant_nxt = '0;
        w_mask_nxt  = '0;
        if (!r_grant_valid || (ARB_BLOCK == 0)) begin
            w_rel = 1'b1;
        end else if (ARB_BLOCK_ACK != 0) begin
            w_rel = ack[r_grant_index];
        end else begin
            w_rel = !req[r_grant_index];
        end
        w_masked = req & r_rr_mask;
        w_enc_m  = f_prio_enc(w_masked);
        w_enc_u  = f_prio_enc(req);
        if ((ARB_ROUND_ROBIN != 0) && w_enc_m[IDX_W]) begin
            w_win = w_enc_m;
        end else begin
            w_win = w_enc_u;
        end
        for (int i = 0; i < PORTS; i++) begin
            w_grant_nxt[i] = (IDX_W'(i) == w_win[IDX_W-1:0]);
            // Mask marks ports that come after the winner in priority order.
            if (LSB_HIGH_PRIO != 0) begin
                w_mask_nxt[i] = (IDX_W'(i) > w_win[IDX_W-1:0]);
            end else begin
                w_mask_nxt[i] = (IDX_W'(i) < w_win[IDX_W-1:0]);
            end
        end
    end

    // Grant and round-robin state; everything holds while the current grant is not released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_index <= '0;
            r_rr_mask     <= '0;
        end else if (w_rel) begin
            if (w_win[IDX_W]) begin
                r_grant       <= w_grant_nxt;
                r_grant_valid <= 1'b1;
                r_grant_index <= w_win[IDX_W-1:0];
                if (ARB_ROUND_ROBIN != 0) begin
                    r_rr_mask <= w_mask_nxt;
                end else begin
                    r_rr_mask <= '0;
                end
            end else begin
                r_grant       <= '0;
                r_grant_valid <= 1'b0;
            end
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_index = r_grant_index;

endmodule
